// File: rtl/s9io_axi_regs_if.sv
// AXI4-Lite slave bundle for the s9io register block (6-bit byte address, 32-bit data).
interface s9io_axi_regs_if;
  logic [5:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [5:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/s9io_axi_regs.sv
// s9io control/status register block: AXI4-Lite slave fronting the cmd/work FIFOs,
// control registers, status and a level interrupt.
module s9io_axi_regs #(
  parameter logic [31:0] BUILD_ID_VAL = 32'h0
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  s9io_axi_regs_if.slave s_axi,
  input  logic [31:0] cmd_rx_data,
  input  logic [31:0] work_rx_data,
  output logic        cmd_rx_pop,
  output logic        work_rx_pop,
  output logic [31:0] cmd_tx_data,
  output logic [31:0] work_tx_data,
  output logic        cmd_tx_push,
  output logic        work_tx_push,
  input  logic [7:0]  fifo_flags,
  input  logic [15:0] work_tx_count,
  input  logic [31:0] err_count,
  input  logic [31:0] last_job_id,
  output logic        ctrl_enable,
  output logic [1:0]  ctrl_midstate,
  output logic [11:0] baud_div,
  output logic [23:0] work_time,
  output logic [15:0] irq_thr,
  output logic [3:0]  rst_fifo,
  output logic        err_cnt_clear,
  output logic        irq
);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Deassertion is re-timed through two flops; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  logic        en_q, en_d;
  logic [1:0]  mid_q, mid_d;
  logic [2:0]  irqen_q, irqen_d;          // {work_rx, work_tx, cmd_rx}
  logic [11:0] baud_q, baud_d;
  logic [23:0] wt_q, wt_d;
  logic [15:0] thr_q, thr_d;
  logic [4:0]  pulse_q, pulse_d;          // {err_cnt_clear, rst_fifo[3:0]}
  logic        ctp_q, ctp_d, wtp_q, wtp_d;
  logic [31:0] ctd_q, ctd_d, wtd_q, wtd_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d, irq_q, irq_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, ctrl_rd, mrg;
  logic [2:0]  pend;
  logic        wr_hs, rd_hs;

  assign wr_hs = rst_n & s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
  assign rd_hs = rst_n & s_axi.arvalid & ~rvalid_q;
  assign ctrl_rd = {16'b0, en_q, mid_q, irqen_q, 10'b0};
  assign pend    = {~fifo_flags[4], (work_tx_count < thr_q), ~fifo_flags[0]};
  assign irq_d   = en_q & |(pend & irqen_q);

  always_comb begin
    en_d = en_q; mid_d = mid_q; irqen_d = irqen_q;
    baud_d = baud_q; wt_d = wt_q; thr_d = thr_q;
    pulse_d = 5'b0; ctp_d = 1'b0; wtp_d = 1'b0; ctd_d = ctd_q; wtd_d = wtd_q;
    bvalid_d = bvalid_q & ~s_axi.bready; bresp_d = bresp_q; mrg = 32'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = OKAY;
      case (s_axi.awaddr[5:2])
        4'h1: if (s_axi.wstrb == 4'hF && !fifo_flags[3]) begin
                ctp_d = 1'b1; ctd_d = s_axi.wdata;
              end else bresp_d = SLVERR;
        4'h3: if (s_axi.wstrb == 4'hF && !fifo_flags[7]) begin
                wtp_d = 1'b1; wtd_d = s_axi.wdata;
              end else bresp_d = SLVERR;
        4'h4: begin
          mrg     = bmerge(ctrl_rd, s_axi.wdata, s_axi.wstrb);
          en_d    = mrg[15];
          mid_d   = (mrg[14:13] == 2'b11) ? 2'b10 : mrg[14:13];
          irqen_d = mrg[12:10];
          pulse_d = s_axi.wdata[4:0] & {5{s_axi.wstrb[0]}};
        end
        4'h6: begin mrg = bmerge({20'b0, baud_q}, s_axi.wdata, s_axi.wstrb); baud_d = mrg[11:0]; end
        4'h7: begin mrg = bmerge({8'b0, wt_q}, s_axi.wdata, s_axi.wstrb);    wt_d   = mrg[23:0]; end
        4'h8: begin mrg = bmerge({16'b0, thr_q}, s_axi.wdata, s_axi.wstrb);  thr_d  = mrg[15:0]; end
        default: ;
      endcase
    end
  end

  // Pops are combinational so the FWFT FIFO advances on the same edge that captures its head.
  always_comb begin
    rvalid_d = rvalid_q & ~s_axi.rready; rdata_d = rdata_q; rresp_d = rresp_q;
    cmd_rx_pop = 1'b0; work_rx_pop = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = OKAY;
      rdata_d  = 32'b0;
      case (s_axi.araddr[5:2])
        4'h0: if (!fifo_flags[0]) begin cmd_rx_pop = 1'b1; rdata_d = cmd_rx_data; end
              else rresp_d = SLVERR;
        4'h2: if (!fifo_flags[4]) begin work_rx_pop = 1'b1; rdata_d = work_rx_data; end
              else rresp_d = SLVERR;
        4'h4: rdata_d = ctrl_rd;
        4'h5: rdata_d = {19'b0, pend, 2'b0, fifo_flags};
        4'h6: rdata_d = {20'b0, baud_q};
        4'h7: rdata_d = {8'b0, wt_q};
        4'h8: rdata_d = {16'b0, thr_q};
        4'hC: rdata_d = err_count;
        4'hD: rdata_d = last_job_id;
        4'hF: rdata_d = BUILD_ID_VAL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge rst_n)
    if (!rst_n) begin
      en_q <= 1'b0; mid_q <= 2'b0; irqen_q <= 3'b0;
      baud_q <= 12'b0; wt_q <= 24'b0; thr_q <= 16'b0;
      pulse_q <= 5'b0; ctp_q <= 1'b0; wtp_q <= 1'b0; ctd_q <= 32'b0; wtd_q <= 32'b0;
      bvalid_q <= 1'b0; bresp_q <= 2'b0; rvalid_q <= 1'b0; rresp_q <= 2'b0;
      rdata_q <= 32'b0; irq_q <= 1'b0;
    end else begin
      en_q <= en_d; mid_q <= mid_d; irqen_q <= irqen_d;
      baud_q <= baud_d; wt_q <= wt_d; thr_q <= thr_d;
      pulse_q <= pulse_d; ctp_q <= ctp_d; wtp_q <= wtp_d; ctd_q <= ctd_d; wtd_q <= wtd_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d; rvalid_q <= rvalid_d; rresp_q <= rresp_d;
      rdata_q <= rdata_d; irq_q <= irq_d;
    end

  assign s_axi.awready = wr_hs;
  assign s_axi.wready  = wr_hs;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = rd_hs;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign cmd_tx_push   = ctp_q;
  assign cmd_tx_data   = ctd_q;
  assign work_tx_push  = wtp_q;
  assign work_tx_data  = wtd_q;
  assign ctrl_enable   = en_q;
  assign ctrl_midstate = mid_q;
  assign baud_div      = baud_q;
  assign work_time     = wt_q;
  assign irq_thr       = thr_q;
  assign rst_fifo      = pulse_q[3:0];
  assign err_cnt_clear = pulse_q[4];
  assign irq           = irq_q;
endmodule

// File: tb/tb_s9io_axi_regs.sv
// Directed + randomized bench for s9io_axi_regs against an offset-indexed register model.
module tb_s9io_axi_regs;
  localparam logic [31:0] BID = 32'hB00D_0042;
  logic clk = 1'b0, aresetn = 1'b0;
  always #5 clk = ~clk;

  s9io_axi_regs_if axi();
  logic [31:0] cmd_rx_data, work_rx_data, cmd_tx_data, work_tx_data, err_count, last_job_id;
  logic        cmd_rx_pop, work_rx_pop, cmd_tx_push, work_tx_push;
  logic [7:0]  fifo_flags;
  logic [15:0] work_tx_count, irq_thr;
  logic        ctrl_enable, err_cnt_clear, irq;
  logic [1:0]  ctrl_midstate;
  logic [11:0] baud_div;
  logic [23:0] work_time;
  logic [3:0]  rst_fifo;

  s9io_axi_regs #(.BUILD_ID_VAL(BID)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .s_axi(axi.slave),
    .cmd_rx_data(cmd_rx_data), .work_rx_data(work_rx_data),
    .cmd_rx_pop(cmd_rx_pop), .work_rx_pop(work_rx_pop),
    .cmd_tx_data(cmd_tx_data), .work_tx_data(work_tx_data),
    .cmd_tx_push(cmd_tx_push), .work_tx_push(work_tx_push),
    .fifo_flags(fifo_flags), .work_tx_count(work_tx_count),
    .err_count(err_count), .last_job_id(last_job_id),
    .ctrl_enable(ctrl_enable), .ctrl_midstate(ctrl_midstate), .baud_div(baud_div),
    .work_time(work_time), .irq_thr(irq_thr), .rst_fifo(rst_fifo),
    .err_cnt_clear(err_cnt_clear), .irq(irq));

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: register contents by word offset, with the writable bits of each.
  logic [31:0] m_reg [16];
  function automatic logic [31:0] wmask(input int off);
    case (off)
      4: return 32'h0000_FC00;
      6: return 32'h0000_0FFF;
      7: return 32'h00FF_FFFF;
      8: return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] exp_rdata(input int off);
    logic [31:0] st;
    st = {24'b0, fifo_flags};
    if (!fifo_flags[4]) st = st + 32'h1000;
    if (32'(work_tx_count) < m_reg[8]) st = st + 32'h0800;
    if (!fifo_flags[0]) st = st + 32'h0400;
    case (off)
      0: return fifo_flags[0] ? 32'h0 : cmd_rx_data;
      2: return fifo_flags[4] ? 32'h0 : work_rx_data;
      4, 6, 7, 8: return m_reg[off];
      5: return st;
      12: return err_count;
      13: return last_job_id;
      15: return BID;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic exp_irq();
    logic [31:0] c;
    c = m_reg[4];
    return c[15] && ((c[12] && !fifo_flags[4]) || (c[11] && 32'(work_tx_count) < m_reg[8]) ||
                     (c[10] && !fifo_flags[0]));
  endfunction
  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int off;
    off = int'(a[5:2]);
    if (wmask(off) != 0) m_reg[off] = merge(m_reg[off], d, s) & wmask(off);
    if (off == 4 && m_reg[4][14:13] == 2'b11) m_reg[4][13] = 1'b0;
  endtask

  logic [1:0]  o_resp, o_rresp;
  logic        o_ctp, o_wtp, o_pop_c, o_pop_w, o_after;
  logic [31:0] o_ctd, o_wtd, o_rdata;
  logic [4:0]  o_pulse;

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(axi.awready && axi.wready) && n < 20) begin n++; @(negedge clk); end
    check("wr_handshake_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    o_ctp = cmd_tx_push; o_wtp = work_tx_push; o_ctd = cmd_tx_data; o_wtd = work_tx_data;
    o_pulse = {err_cnt_clear, rst_fifo};
    check("bvalid_after_wr", 32'(axi.bvalid), 32'd1);
    o_resp = axi.bresp;
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
    o_after = cmd_tx_push | work_tx_push | err_cnt_clear | (|rst_fifo);
    check("bvalid_cleared", 32'(axi.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [5:0] a);
    int n;
    axi.araddr = a; axi.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.arready && n < 20) begin n++; @(negedge clk); end
    check("rd_handshake_timeout", 32'(n < 20), 32'd1);
    o_pop_c = cmd_rx_pop; o_pop_w = work_rx_pop;
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    check("rvalid_after_rd", 32'(axi.rvalid), 32'd1);
    o_rdata = axi.rdata; o_rresp = axi.rresp;
    axi.rready = 1'b1;
    @(posedge clk); #1;
    axi.rready = 1'b0;
    o_after = cmd_rx_pop | work_rx_pop;
  endtask

  logic [5:0]  ra;
  logic [31:0] rd;
  logic [3:0]  rs;
  logic        ept, ewp;
  int          off;

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    axi.awaddr = 6'h0; axi.wdata = 32'h0; axi.wstrb = 4'h0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = 6'h0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    fifo_flags = 8'h00; work_tx_count = 16'd0; cmd_rx_data = 32'h1111_2222; work_rx_data = 32'h3333_4444;
    err_count = 32'hE000_0007; last_job_id = 32'h0000_BEEF;

    // Reset with requests pending: nothing may handshake, pop or push.
    axi.awaddr = 6'h04; axi.wstrb = 4'hF; axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_pop", 32'(cmd_rx_pop), 32'd0);
    check("rst_valids", {30'b0, axi.bvalid, axi.rvalid}, 32'd0);
    check("rst_outs", {irq, ctrl_enable, ctrl_midstate, rst_fifo, err_cnt_clear, cmd_tx_push, work_tx_push}, 32'd0);
    check("rst_fields", {baud_div, irq_thr}, 32'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("sync_no_early_hs", {30'b0, axi.awready, axi.arready}, 32'd0);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_push_none", 32'(cmd_tx_push), 32'd0);

    // CTRL write/readback, including midstate coercion.
    axi_write(6'h10, 32'h0000_DC00, 4'hF); model_write(6'h10, 32'h0000_DC00, 4'hF);
    check("ctrl_wr_resp", 32'(o_resp), 32'd0);
    axi_read(6'h10);
    check("ctrl_rd", o_rdata, 32'h0000_DC00);
    check("ctrl_rd_resp", 32'(o_rresp), 32'd0);
    check("ctrl_en_mid", {29'b0, ctrl_enable, ctrl_midstate}, 32'b110);
    axi_write(6'h10, 32'h0000_E000, 4'hF); model_write(6'h10, 32'h0000_E000, 4'hF);
    check("mid11_to_10", 32'(ctrl_midstate), 32'd2);

    // Pulse bits.
    axi_write(6'h10, 32'h0000_001F, 4'hF); model_write(6'h10, 32'h0000_001F, 4'hF);
    check("pulse_all", 32'(o_pulse), 32'h1F);
    check("pulse_one_cycle", 32'(o_after), 32'd0);
    axi_read(6'h10);
    check("ctrl_after_pulse", o_rdata, 32'h0);

    // WORK_TX full / strobe / ok.
    fifo_flags = 8'h80;
    axi_write(6'h0C, 32'hCAFE_0001, 4'hF);
    check("wtx_full_push", 32'(o_wtp), 32'd0);
    check("wtx_full_resp", 32'(o_resp), 32'd2);
    fifo_flags = 8'h00;
    axi_write(6'h0C, 32'hCAFE_0002, 4'h7);
    check("wtx_strb_push", 32'(o_wtp), 32'd0);
    check("wtx_strb_resp", 32'(o_resp), 32'd2);
    axi_write(6'h0C, 32'hCAFE_0003, 4'hF);
    check("wtx_push", 32'(o_wtp), 32'd1);
    check("wtx_data", o_wtd, 32'hCAFE_0003);
    check("wtx_resp", 32'(o_resp), 32'd0);
    check("wtx_push_one_cycle", 32'(o_after), 32'd0);

    // CMD_RX non-empty / empty.
    fifo_flags = 8'h00; cmd_rx_data = 32'hA5A5_0001;
    axi_read(6'h00);
    check("crx_pop", 32'(o_pop_c), 32'd1);
    check("crx_data", o_rdata, 32'hA5A5_0001);
    check("crx_resp", 32'(o_rresp), 32'd0);
    check("crx_single_pop", 32'(o_after), 32'd0);
    fifo_flags = 8'h01;
    axi_read(6'h00);
    check("crx_empty_pop", 32'(o_pop_c), 32'd0);
    check("crx_empty_data", o_rdata, 32'h0);
    check("crx_empty_resp", 32'(o_rresp), 32'd2);

    // Threshold interrupt.
    fifo_flags = 8'h11; work_tx_count = 16'd15;
    axi_write(6'h20, 32'd16, 4'hF); model_write(6'h20, 32'd16, 4'hF);
    axi_write(6'h10, 32'h0000_8800, 4'hF); model_write(6'h10, 32'h0000_8800, 4'hF);
    repeat (2) @(posedge clk); #1;
    check("irq_below_thr", 32'(irq), 32'd1);
    work_tx_count = 16'd16;
    repeat (2) @(posedge clk); #1;
    check("irq_at_thr", 32'(irq), 32'd0);
    work_tx_count = 16'd15;
    axi_write(6'h10, 32'h0000_0800, 4'hF); model_write(6'h10, 32'h0000_0800, 4'hF);
    repeat (2) @(posedge clk); #1;
    check("irq_disabled", 32'(irq), 32'd0);

    axi_read(6'h3D);
    check("build_id", o_rdata, BID);

    // Random traffic against the model.
    for (int it = 0; it < 120; it++) begin
      fifo_flags = 8'($urandom); work_tx_count = 16'($urandom_range(0, 40));
      cmd_rx_data = $urandom; work_rx_data = $urandom; err_count = $urandom; last_job_id = $urandom;
      ra = 6'($urandom); rd = $urandom;
      if (ra[5:2] == 4'h8 && rd[0]) rd = rd & 32'h3F;
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      off = int'(ra[5:2]);
      if ($urandom_range(0, 1) == 1) begin
        axi_write(ra, rd, rs);
        ept = (off == 1) && rs == 4'hF && !fifo_flags[3];
        ewp = (off == 3) && rs == 4'hF && !fifo_flags[7];
        check("r_bresp", 32'(o_resp), ((off == 1 || off == 3) && !(ept || ewp)) ? 32'd2 : 32'd0);
        check("r_push", {30'b0, o_ctp, o_wtp}, {30'b0, ept, ewp});
        if (ept) check("r_ctx_data", o_ctd, rd);
        if (ewp) check("r_wtx_data", o_wtd, rd);
        check("r_pulse", 32'(o_pulse), (off == 4 && rs[0]) ? 32'(rd[4:0]) : 32'd0);
        model_write(ra, rd, rs);
      end else begin
        axi_read(ra);
        check("r_rdata", o_rdata, exp_rdata(off));
        check("r_rresp", 32'(o_rresp), ((off == 0 && fifo_flags[0]) || (off == 2 && fifo_flags[4])) ? 32'd2 : 32'd0);
        check("r_pop", {30'b0, o_pop_c, o_pop_w},
              {30'b0, off == 0 && !fifo_flags[0], off == 2 && !fifo_flags[4]});
      end
      @(posedge clk); #1;
      check("r_irq", 32'(irq), 32'(exp_irq()));
      check("r_ctrl_out", {16'b0, ctrl_enable, ctrl_midstate, 13'b0}, m_reg[4] & 32'h0000_E000);
      check("r_fields", {8'b0, work_time}, m_reg[7]);
      check("r_baud_thr", {baud_div, 4'b0, irq_thr}, {m_reg[6][11:0], 4'b0, m_reg[8][15:0]});
    end

    // Read held by rready low, then reset mid-hold.
    last_job_id = 32'h1234_5678;
    axi.araddr = 6'h34; axi.arvalid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20 && !axi.arready; n++) @(negedge clk);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_rvalid", 32'(axi.rvalid), 32'd1);
      check("hold_rdata", axi.rdata, 32'h1234_5678);
      check("hold_no_arready", 32'(axi.arready), 32'd0);
    end
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_mid_pop", {30'b0, cmd_rx_pop, work_rx_pop}, 32'd0);
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    axi.arvalid = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (3) @(posedge clk); #1;
    axi_read(6'h18);
    check("baud_after_rst", o_rdata, m_reg[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/s9io_axi_regs.md
S9IO_AXI_REGS -- requirements
Module: s9io_axi_regs

Interface
REQ-001 Parameter BUILD_ID_VAL, default 32'h0, value returned at offset 0x3C.
REQ-002 Port s_axi_aclk  input  1  sole clock; all logic rising-edge.
REQ-003 Port s_axi_aresetn  input  1  asynchronous, active-low reset.
REQ-004 Ports AXI4-Lite slave: awaddr[5:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr[5:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready; standard directions.
REQ-005 Ports cmd_rx_data[31:0]/work_rx_data[31:0] in, cmd_rx_pop/work_rx_pop out 1: FWFT RX FIFO read side.
REQ-006 Ports cmd_tx_data[31:0]/work_tx_data[31:0] out, cmd_tx_push/work_tx_push out 1: TX FIFO write side.
REQ-007 Ports fifo_flags[7:0] in {work_tx_full, work_tx_empty, work_rx_full, work_rx_empty, cmd_tx_full, cmd_tx_empty, cmd_rx_full, cmd_rx_empty}; work_tx_count[15:0] in (words).
REQ-008 Ports err_count[31:0] in, last_job_id[31:0] in; read-only sources.
REQ-009 Ports ctrl_enable out 1, ctrl_midstate[1:0] out, baud_div[11:0] out, work_time[23:0] out, irq_thr[15:0] out.
REQ-010 Ports rst_fifo[3:0] out {work_tx, work_rx, cmd_tx, cmd_rx}, err_cnt_clear out 1, irq out 1.

Function
REQ-011 Offsets: 0x00 CMD_RX rd, 0x04 CMD_TX wr, 0x08 WORK_RX rd, 0x0C WORK_TX wr, 0x10 CTRL rw, 0x14 STAT ro, 0x18 BAUD rw, 0x1C WORK_TIME rw, 0x20 IRQ_FIFO_THR rw, 0x30 ERR_COUNTER ro, 0x34 LAST_JOB_ID ro, 0x3C BUILD_ID ro; addr[1:0] ignored.
REQ-012 Write channel: awready and wready asserted together for exactly one cycle only when awvalid&wvalid and bvalid low; register/push effect on that edge; bvalid next cycle, held until bready.
REQ-013 Read channel: arready one cycle when arvalid and rvalid low; rdata/rresp registered, rvalid next cycle, held stable until rready.
REQ-014 Only one outstanding transaction per channel; read and write channels independent and may complete in same cycle.
REQ-015 CTRL bits: [15] enable, [14:13] midstate, [12] irq_en_work_rx, [11] irq_en_work_tx, [10] irq_en_cmd_rx stored; [4:0] write-only pulses read as 0; other bits read 0.
REQ-016 Writing 1 to CTRL[4]/[3]/[2]/[1]/[0] pulses err_cnt_clear/rst_fifo[3..0] high exactly one cycle after the write edge.
REQ-017 Midstate write value 2'b11 stored as 2'b10.
REQ-018 wstrb applied per byte to CTRL/BAUD/WORK_TIME/IRQ_FIFO_THR; FIFO pushes require wstrb==4'hF else SLVERR, no push.
REQ-019 Write to CMD_TX/WORK_TX: push one-cycle pulse with wdata; if corresponding full flag set, no push, bresp SLVERR.
REQ-020 Read of CMD_RX/WORK_RX: pop one-cycle pulse on arready edge, rdata = FIFO data; if empty, no pop, rdata 0, rresp SLVERR.
REQ-021 STAT = {pend_work_rx[12], pend_work_tx[11], pend_cmd_rx[10], fifo_flags[7:0]}, others 0.
REQ-022 pend_work_rx = !work_rx_empty; pend_work_tx = work_tx_count < irq_thr; pend_cmd_rx = !cmd_rx_empty.
REQ-023 irq registered: OR of (pending & enable) per source, one-cycle latency; irq forced 0 while ctrl_enable=0.
REQ-024 Writes to read-only/unmapped offsets ignored, bresp OKAY; reads of unmapped/write-only offsets return 0, OKAY.
REQ-025 Writable field widths truncate wdata: BAUD [11:0], WORK_TIME [23:0], THR [15:0]; upper bits read 0.

Reset
REQ-026 Async assert: all registers 0, awready/wready/arready/bvalid/rvalid/irq/push/pop/rst_fifo/err_cnt_clear 0; outstanding transactions dropped.
REQ-027 Deassert synchronised to s_axi_aclk (2-flop); no handshake before second rising edge after release.
REQ-028 Reset mid-transaction: no push/pop emitted for the aborted transaction.

Verification
REQ-029 Write 0x10=0x0000DC00 then read -> rdata 0x0000DC00, ctrl_enable=1, midstate=2'b10, OKAY.
REQ-030 Write 0x10=0x0000001F -> err_cnt_clear and rst_fifo=4'hF high one cycle; readback 0x0.
REQ-031 work_tx_full=1, write 0x0C -> no work_tx_push, bresp 2'b10; full=0 -> push with wdata.
REQ-032 cmd_rx_empty=0, data 0xA5A5_0001, read 0x00 -> single cmd_rx_pop, rdata 0xA5A50001; empty=1 -> rdata 0, SLVERR.
REQ-033 CTRL=0x8800, irq_thr=16, work_tx_count 15 -> irq=1; count 16 -> irq=0; enable=0 -> irq=0.
REQ-034 rready held low 5 cycles -> rvalid/rdata stable, no second arready; aresetn pulse mid-hold -> rvalid 0.
